// File: rtl/bus_node_receiver_if.sv
// Bus-side signal bundle for bus_node_receiver: serial line in, latched frame and status pulses out.
interface bus_node_receiver_if;
  logic        bus_in;
  logic [63:0] data_out;
  logic [3:0]  sender_out;
  logic [3:0]  crc_out;
  logic        valid;
  logic        crc_err;
  logic        frame_err;
  logic        busy;

  modport master (
    output bus_in,
    input  data_out, sender_out, crc_out, valid, crc_err, frame_err, busy
  );

  modport slave (
    input  bus_in,
    output data_out, sender_out, crc_out, valid, crc_err, frame_err, busy
  );
endinterface

// File: rtl/bus_node_receiver.sv
// Serial bus receiver: frames 78-bit packets, filters on destination, optionally checks CRC-4.
// Optional feature macro: BUS_RX_CRC_CHECK_EN (running CRC and crc_err pulse).
module bus_node_receiver #(
  parameter logic [3:0] NODE_ADDR = 4'd1
) (
  input  logic               clock,
  input  logic               reset,
  bus_node_receiver_if.slave bus
);

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned CRC_W  = 4;
  localparam int unsigned CNT_W  = 7;
  localparam int unsigned ST_W   = 3;

  localparam logic [ST_W-1:0] S_IDLE = 3'd0;
  localparam logic [ST_W-1:0] S_SRC  = 3'd1;
  localparam logic [ST_W-1:0] S_DST  = 3'd2;
  localparam logic [ST_W-1:0] S_DATA = 3'd3;
  localparam logic [ST_W-1:0] S_CRC  = 3'd4;
  localparam logic [ST_W-1:0] S_STOP = 3'd5;

  logic [ST_W-1:0]   r_state;
  logic [ST_W-1:0]   w_state_nxt;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [CNT_W-1:0]  w_bit_cnt_nxt;

  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [DATA_W-1:0] r_data;
  logic [CRC_W-1:0]  r_crc_rx;

  logic [DATA_W-1:0] r_data_out;
  logic [ADDR_W-1:0] r_sender_out;
  logic [CRC_W-1:0]  r_crc_out;
  logic              r_valid;
  logic              r_frame_err;
  logic              r_busy;

  logic              w_bit;
  logic              w_at_stop;
  logic              w_addr_hit;
  logic              w_crc_ok;
  logic              w_accept;

  assign w_bit      = bus.bus_in;
  assign w_at_stop  = (r_state == S_STOP);
  assign w_addr_hit = (r_dst == NODE_ADDR);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
    end
  end

  // Next-state logic: each field advances when its bit counter reaches the field length
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
    case (r_state)
      S_IDLE: begin
        w_bit_cnt_nxt = '0;
        if (w_bit) w_state_nxt = S_SRC;
      end
      S_SRC: begin
        if (r_bit_cnt == CNT_W'(ADDR_W - 1)) begin
          w_state_nxt   = S_DST;
          w_bit_cnt_nxt = '0;
        end
      end
      S_DST: begin
        if (r_bit_cnt == CNT_W'(ADDR_W - 1)) begin
          w_state_nxt   = S_DATA;
          w_bit_cnt_nxt = '0;
        end
      end
      S_DATA: begin
        if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
          w_state_nxt   = S_CRC;
          w_bit_cnt_nxt = '0;
        end
      end
      S_CRC: begin
        if (r_bit_cnt == CNT_W'(CRC_W - 1)) begin
          w_state_nxt   = S_STOP;
          w_bit_cnt_nxt = '0;
        end
      end
      S_STOP: begin
        w_state_nxt   = S_IDLE;
        w_bit_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_bit_cnt_nxt = '0;
      end
    endcase
  end

  // Field shift registers, MSB first
  always_ff @(posedge clock) begin
    if (reset) begin
      r_src    <= '0;
      r_dst    <= '0;
      r_data   <= '0;
      r_crc_rx <= '0;
    end else begin
      case (r_state)
        S_SRC:   r_src    <= {r_src[ADDR_W-2:0], w_bit};
        S_DST:   r_dst    <= {r_dst[ADDR_W-2:0], w_bit};
        S_DATA:  r_data   <= {r_data[DATA_W-2:0], w_bit};
        S_CRC:   r_crc_rx <= {r_crc_rx[CRC_W-2:0], w_bit};
        default: ;
      endcase
    end
  end

`ifdef BUS_RX_CRC_CHECK_EN
  localparam logic [CRC_W-1:0] CRC_POLY = 4'b0011;

  logic [CRC_W-1:0] r_crc_calc;
  logic             w_crc_fb;
  logic             w_crc_bit_en;
  logic             r_crc_err;

  assign w_crc_fb     = r_crc_calc[CRC_W-1] ^ w_bit;
  assign w_crc_bit_en = (r_state == S_SRC) || (r_state == S_DST) || (r_state == S_DATA);

  // Running CRC over src/dst/data, restarted on each start bit
  always_ff @(posedge clock) begin
    if (reset) begin
      r_crc_calc <= '0;
    end else if ((r_state == S_IDLE) && w_bit) begin
      r_crc_calc <= '0;
    end else if (w_crc_bit_en) begin
      r_crc_calc <= {r_crc_calc[CRC_W-2:0], 1'b0} ^ (w_crc_fb ? CRC_POLY : '0);
    end
  end

  assign w_crc_ok = (r_crc_calc == r_crc_rx);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_crc_err <= 1'b0;
    end else begin
      r_crc_err <= w_at_stop && !w_bit && w_addr_hit && !w_crc_ok;
    end
  end

  assign bus.crc_err = r_crc_err;
`else
  assign w_crc_ok    = 1'b1;
  assign bus.crc_err = 1'b0;
`endif

  assign w_accept = w_at_stop && !w_bit && w_addr_hit && w_crc_ok;

  // Stop-bit decision: outputs only change here, pulses last one cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      r_data_out   <= '0;
      r_sender_out <= '0;
      r_crc_out    <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_valid     <= w_accept;
      r_frame_err <= w_at_stop && w_bit;
      r_busy      <= (w_state_nxt != S_IDLE);
      if (w_accept) begin
        r_data_out   <= r_data;
        r_sender_out <= r_src;
        r_crc_out    <= r_crc_rx;
      end
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.sender_out = r_sender_out;
  assign bus.crc_out    = r_crc_out;
  assign bus.valid      = r_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_bus_node_receiver.sv
// Self-checking bench for bus_node_receiver: directed frames plus randomized frames against a frame-level model.
module tb_bus_node_receiver;

  localparam logic [3:0] NODE = 4'd1;
`ifdef BUS_RX_CRC_CHECK_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic clock;
  logic reset;
  int   total;
  int   bad;

  // model state: held outputs and the pending stop-bit outcome
  logic [63:0] h_data;
  logic [3:0]  h_src;
  logic [3:0]  h_crc;
  bit          pend;
  logic [2:0]  e_pulse;

  bus_node_receiver_if bif ();

  bus_node_receiver #(.NODE_ADDR(NODE)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // CRC-4 (x^4+x+1) as remainder of msg * x^4 by polynomial long division
  function automatic logic [3:0] crc_ref(input logic [71:0] msg);
    logic [75:0] r;
    r = {msg, 4'b0000};
    for (int i = 75; i >= 4; i--) begin
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input bit chk_busy);
    if (chk_busy) chk("busy_idle", 64'(bif.busy), 64'd0);
    chk("pulses", 64'({bif.valid, bif.crc_err, bif.frame_err}), pend ? 64'(e_pulse) : 64'd0);
    chk("data_out", bif.data_out, h_data);
    chk("sender_out", 64'(bif.sender_out), 64'(h_src));
    chk("crc_out", 64'(bif.crc_out), 64'(h_crc));
    pend = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input bit chk_busy);
    repeat (n) begin
      @(negedge clock);
      check_result(chk_busy);
      bif.bus_in = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [3:0] src, input logic [3:0] dst,
                            input logic [63:0] data, input logic [3:0] crc, input logic stop);
    logic [77:0] f;
    f = {1'b1, src, dst, data, crc, stop};
    for (int i = 0; i < 78; i++) begin
      @(negedge clock);
      if (i == 0) begin
        check_result(1'b1);
      end else begin
        chk("busy_frame", 64'(bif.busy), 64'd1);
        chk("pulse_in_frame", 64'({bif.valid, bif.crc_err, bif.frame_err}), 64'd0);
      end
      bif.bus_in = f[77-i];
    end
    pend    = 1'b1;
    e_pulse = 3'b000;
    if (stop) begin
      e_pulse = 3'b001;
    end else if (dst == NODE) begin
      if (!CRC_ON || (crc == crc_ref({src, dst, data}))) begin
        e_pulse = 3'b100;
        h_data  = data;
        h_src   = src;
        h_crc   = crc;
      end else begin
        e_pulse = 3'b010;
      end
    end
  endtask

  initial begin
    logic [77:0] f;
    logic [3:0]  s, d, c;
    logic [63:0] dat;
    logic        st;

    total = 0; bad = 0;
    pend = 1'b0; e_pulse = 3'b000;
    h_data = '0; h_src = '0; h_crc = '0;
    bif.bus_in = 1'b0;
    reset = 1'b1;

    repeat (3) @(negedge clock);
    check_result(1'b1);
    reset = 1'b0;
    idle_cycles(2, 1'b1);

    // good frame, then bad-CRC frame
    send_frame(4'h0, 4'h1, 64'h0, 4'h5, 1'b0);
    send_frame(4'h0, 4'h1, 64'h1, 4'h5, 1'b0);
    idle_cycles(3, 1'b1);

    // address filter followed by back-to-back good frame
    send_frame(4'h2, 4'h3, 64'hDEADBEEF_CAFEF00D, 4'hA, 1'b0);
    send_frame(4'h0, 4'h1, 64'h1, 4'h6, 1'b0);

    // framing error, then bus stays idle
    send_frame(4'h0, 4'h1, 64'h0, 4'h5, 1'b1);
    idle_cycles(5, 1'b1);

    // randomized frames with random gaps
    for (int k = 0; k < 30; k++) begin
      s   = 4'($urandom_range(0, 15));
      d   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : NODE;
      dat = {$urandom, $urandom};
      c   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : crc_ref({s, d, dat});
      st  = ($urandom_range(0, 7) == 0);
      send_frame(s, d, dat, c, st);
      idle_cycles($urandom_range(0, 2), 1'b1);
    end
    idle_cycles(2, 1'b1);

    // reset asserted at bit 40 of a frame for this node
    f = {1'b1, 4'h0, 4'h1, 64'h0, 4'h5, 1'b0};
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      bif.bus_in = f[77-i];
    end
    @(negedge clock);
    reset = 1'b1;
    bif.bus_in = f[37];
    @(negedge clock);
    reset = 1'b0;
    h_data = '0; h_src = '0; h_crc = '0;
    pend = 1'b0;
    check_result(1'b1);
    bif.bus_in = f[36];
    for (int i = 42; i < 78; i++) begin
      @(negedge clock);
      check_result(1'b0);
      bif.bus_in = f[77-i];
    end
    idle_cycles(80, 1'b0);
    idle_cycles(1, 1'b1);

    // full good frame after the aborted one
    dat = {$urandom, $urandom};
    send_frame(4'h7, NODE, dat, crc_ref({4'h7, NODE, dat}), 1'b0);
    idle_cycles(2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
